rgb_ycbcr_csc: RTL and testbench

- Parametrised RGB-to-YCbCr colour-space converter for the video pixel stream.
- Selectable BT.601 / BT.709 coefficient sets plus a bypass mode.
- Full valid/ready backpressure, rounding and saturation; alpha/blank lane carried alongside the pixel.
- Sits between the RGB source (camera/DMA unpacker) and downstream YCbCr consumers (chroma subsampler, encoder).

---
 rtl/csc_pkg.sv | 58 +++++
 rtl/csc_mul_rnd.sv | 33 +++
 rtl/rgb_ycbcr_csc.sv | 154 +++++++++++++++
 tb/tb_rgb_ycbcr_csc.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/csc_pkg.sv
// Shared definitions for the RGB-to-YCbCr converter: mode encodings,
// coefficient tables and the small arithmetic helpers used by the pipeline.
package csc_pkg;

    typedef enum logic [1:0] {
        CSC_BT601  = 2'd0,
        CSC_BT709  = 2'd1,
        CSC_BYPASS = 2'd2
    } csc_mode_e;

    // Coefficients in Q0.16; rescaled to COEF_FRAC at the point of use.
    localparam logic [15:0] BT601_KR  = 16'd19595;
    localparam logic [15:0] BT601_KB  = 16'd7471;
    localparam logic [15:0] BT601_KCR = 16'd46745;
    localparam logic [15:0] BT601_KCB = 16'd36984;
    localparam logic [15:0] BT709_KR  = 16'd13933;
    localparam logic [15:0] BT709_KB  = 16'd4732;
    localparam logic [15:0] BT709_KCR = 16'd41615;
    localparam logic [15:0] BT709_KCB = 16'd35318;

    typedef struct packed {
        logic [15:0] kr;
        logic [15:0] kb;
        logic [15:0] kcr;
        logic [15:0] kcb;
    } csc_coef_t;

    // Both bypass encodings return zeros; the products are ignored then.
    function automatic csc_coef_t csc_coefs(input logic [1:0] mode);
        csc_coef_t c;
        case (mode)
            CSC_BT601: c = '{kr: BT601_KR, kb: BT601_KB, kcr: BT601_KCR, kcb: BT601_KCB};
            CSC_BT709: c = '{kr: BT709_KR, kb: BT709_KB, kcr: BT709_KCR, kcb: BT709_KCB};
            default:   c = '0;
        endcase
        return c;
    endfunction

    function automatic logic [31:0] csc_scale(input logic [15:0] k, input int unsigned frac);
        if (frac >= 16) begin
            return {16'd0, k} << (frac - 16);
        end
        return {16'd0, k} >> (16 - frac);
    endfunction

    function automatic int csc_sat(input int v, input int unsigned pix_w);
        int hi;
        hi = (1 << pix_w) - 1;
        if (v < 0) begin
            return 0;
        end
        if (v > hi) begin
            return hi;
        end
        return v;
    endfunction

endpackage

// File: rtl/csc_mul_rnd.sv
// Signed difference times unsigned Q0.COEF_FRAC coefficient. The product is
// registered; the rounded (ties toward +inf) result is taken from that register.
module csc_mul_rnd #(
    parameter int unsigned DIFF_W    = 9,
    parameter int unsigned COEF_FRAC = 16
) (
    input  logic                     clk,
    input  logic                     i_en,
    input  logic signed [DIFF_W-1:0] i_diff,
    input  logic [COEF_FRAC-1:0]     i_coef,
    output logic signed [DIFF_W:0]   o_rnd
);

    localparam int unsigned PROD_W = DIFF_W + COEF_FRAC + 1;
    localparam int unsigned RND_W  = DIFF_W + 1;
    localparam logic signed [PROD_W-1:0] HALF = PROD_W'(1 << (COEF_FRAC - 1));

    logic signed [PROD_W-1:0] w_prod;
    logic signed [PROD_W-1:0] w_biased;
    logic signed [PROD_W-1:0] r_prod;

    assign w_prod = PROD_W'(i_diff) * PROD_W'($signed({1'b0, i_coef}));

    always_ff @(posedge clk) begin
        if (i_en) begin
            r_prod <= w_prod;
        end
    end

    assign w_biased = r_prod + HALF;
    assign o_rnd    = RND_W'(w_biased >>> COEF_FRAC);

endmodule

// File: rtl/rgb_ycbcr_csc.sv
// Four-stage RGB-to-YCbCr converter with per-pixel mode, rounding, saturation
// and a single global advance enable for valid/ready backpressure.
module rgb_ycbcr_csc
    import csc_pkg::*;
#(
    parameter int unsigned PIX_W     = 8,
    parameter int unsigned COEF_FRAC = 16,
    parameter int          Y_OFFSET  = 0,
    parameter int          C_OFFSET  = 2 ** (PIX_W - 1)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [1:0]         cfg_mode,
    input  logic [4*PIX_W-1:0] s_data,
    input  logic               s_valid,
    output logic               s_ready,
    output logic [4*PIX_W-1:0] m_data,
    output logic               m_valid,
    input  logic               m_ready,
    output logic               m_sat
);

    localparam int unsigned DW = 4 * PIX_W;
    localparam int unsigned YW = PIX_W + 2;
    localparam int unsigned CW = PIX_W + 3;

    logic                 r_s1_valid, r_s2_valid, r_s3_valid, r_s4_valid;
    logic [DW-1:0]        r_s1_px, r_s2_px, r_s3_px;
    logic                 r_s1_byp, r_s2_byp, r_s3_byp;
    logic [COEF_FRAC-1:0] r_s1_kcr, r_s1_kcb, r_s2_kcr, r_s2_kcb;
    logic signed [YW-1:0] r_s2_y, r_s3_y;
    logic [DW-1:0]        r_m_data;
    logic                 r_m_sat;

    logic                 w_adv;
    logic                 w_take;
    csc_coef_t            w_coefs;
    logic [COEF_FRAC-1:0] w_kr, w_kb, w_kcr, w_kcb;
    logic signed [PIX_W:0] w_d_rg, w_d_bg;
    logic signed [YW-1:0] w_rnd_r, w_rnd_b, w_y, w_d_ry, w_d_by;
    logic signed [CW-1:0] w_rnd_cr, w_rnd_cb;
    logic [DW-1:0]        w_csc_px;
    logic                 w_clip;
    int                   w_y_full, w_cr_full, w_cb_full;
    int                   w_y_sat, w_cr_sat, w_cb_sat;

    assign w_adv   = !r_s4_valid || m_ready;
    assign s_ready = w_adv && !rst;
    assign w_take  = s_valid && s_ready;

    // Stage 1: luma products from the incoming pixel, chroma coefs latched with it.
    assign w_coefs = csc_coefs(cfg_mode);
    assign w_kr    = COEF_FRAC'(csc_scale(w_coefs.kr, COEF_FRAC));
    assign w_kb    = COEF_FRAC'(csc_scale(w_coefs.kb, COEF_FRAC));
    assign w_kcr   = COEF_FRAC'(csc_scale(w_coefs.kcr, COEF_FRAC));
    assign w_kcb   = COEF_FRAC'(csc_scale(w_coefs.kcb, COEF_FRAC));
    assign w_d_rg  = $signed({1'b0, s_data[2*PIX_W-1:PIX_W]})
                   - $signed({1'b0, s_data[3*PIX_W-1:2*PIX_W]});
    assign w_d_bg  = $signed({1'b0, s_data[4*PIX_W-1:3*PIX_W]})
                   - $signed({1'b0, s_data[3*PIX_W-1:2*PIX_W]});

    csc_mul_rnd #(.DIFF_W(PIX_W + 1), .COEF_FRAC(COEF_FRAC)) u_mul_r (
        .clk    (clk),
        .i_en   (w_adv),
        .i_diff (w_d_rg),
        .i_coef (w_kr),
        .o_rnd  (w_rnd_r)
    );

    csc_mul_rnd #(.DIFF_W(PIX_W + 1), .COEF_FRAC(COEF_FRAC)) u_mul_b (
        .clk    (clk),
        .i_en   (w_adv),
        .i_diff (w_d_bg),
        .i_coef (w_kb),
        .o_rnd  (w_rnd_b)
    );

    // Stage 2: unclipped luma.
    assign w_y = $signed({2'b00, r_s1_px[3*PIX_W-1:2*PIX_W]}) + w_rnd_r + w_rnd_b;

    // Stage 3: chroma products against the unclipped luma.
    assign w_d_ry = $signed({2'b00, r_s2_px[2*PIX_W-1:PIX_W]}) - r_s2_y;
    assign w_d_by = $signed({2'b00, r_s2_px[4*PIX_W-1:3*PIX_W]}) - r_s2_y;

    csc_mul_rnd #(.DIFF_W(YW), .COEF_FRAC(COEF_FRAC)) u_mul_cr (
        .clk    (clk),
        .i_en   (w_adv),
        .i_diff (w_d_ry),
        .i_coef (r_s2_kcr),
        .o_rnd  (w_rnd_cr)
    );

    csc_mul_rnd #(.DIFF_W(YW), .COEF_FRAC(COEF_FRAC)) u_mul_cb (
        .clk    (clk),
        .i_en   (w_adv),
        .i_diff (w_d_by),
        .i_coef (r_s2_kcb),
        .o_rnd  (w_rnd_cb)
    );

    // Stage 4: offsets, saturation and output packing.
    always_comb begin
        w_y_full  = int'(r_s3_y) + Y_OFFSET;
        w_cr_full = int'(w_rnd_cr) + C_OFFSET;
        w_cb_full = int'(w_rnd_cb) + C_OFFSET;
        w_y_sat   = csc_sat(w_y_full, PIX_W);
        w_cr_sat  = csc_sat(w_cr_full, PIX_W);
        w_cb_sat  = csc_sat(w_cb_full, PIX_W);
        w_clip    = (w_y_sat != w_y_full) || (w_cr_sat != w_cr_full)
                 || (w_cb_sat != w_cb_full);
        w_csc_px  = {PIX_W'(w_y_sat), PIX_W'(w_cr_sat), PIX_W'(w_cb_sat),
                     r_s3_px[PIX_W-1:0]};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_s1_valid <= 1'b0;
            r_s2_valid <= 1'b0;
            r_s3_valid <= 1'b0;
            r_s4_valid <= 1'b0;
            r_m_data   <= '0;
            r_m_sat    <= 1'b0;
        end else if (w_adv) begin
            r_s1_valid <= w_take;
            r_s2_valid <= r_s1_valid;
            r_s3_valid <= r_s2_valid;
            r_s4_valid <= r_s3_valid;
            r_m_data   <= r_s3_byp ? r_s3_px : w_csc_px;
            r_m_sat    <= !r_s3_byp && w_clip;
        end
    end

    always_ff @(posedge clk) begin
        if (w_adv) begin
            r_s1_px  <= s_data;
            r_s1_byp <= cfg_mode[1];
            r_s1_kcr <= w_kcr;
            r_s1_kcb <= w_kcb;
            r_s2_px  <= r_s1_px;
            r_s2_byp <= r_s1_byp;
            r_s2_kcr <= r_s1_kcr;
            r_s2_kcb <= r_s1_kcb;
            r_s2_y   <= w_y;
            r_s3_px  <= r_s2_px;
            r_s3_byp <= r_s2_byp;
            r_s3_y   <= r_s2_y;
        end
    end

    assign m_valid = r_s4_valid;
    assign m_data  = r_m_data;
    assign m_sat   = r_m_sat;

endmodule

// File: tb/tb_rgb_ycbcr_csc.sv
// Bench for rgb_ycbcr_csc: hand-computed vector table plus scoreboarded
// sequences for streaming, mode switching, reset and backpressure.
module tb_rgb_ycbcr_csc;

    logic        clk = 1'b0;
    logic        rst;
    logic [1:0]  cfg_mode;
    logic [31:0] s_data;
    logic        s_valid;
    logic        s_ready;
    logic [31:0] m_data;
    logic        m_valid;
    logic        m_ready;
    logic        m_sat;

    rgb_ycbcr_csc #(
        .PIX_W     (8),
        .COEF_FRAC (16),
        .Y_OFFSET  (0),
        .C_OFFSET  (128)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .cfg_mode (cfg_mode),
        .s_data   (s_data),
        .s_valid  (s_valid),
        .s_ready  (s_ready),
        .m_data   (m_data),
        .m_valid  (m_valid),
        .m_ready  (m_ready),
        .m_sat    (m_sat)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [1:0]  md;
        logic [31:0] din;
        logic [31:0] dout;
        logic        sat;
    } vec_t;

    vec_t        vecs[8];
    int          n_checks = 0;
    int          n_errs = 0;
    int          n_acc = 0;
    int          n_out = 0;
    logic [32:0] exp_q[$];
    logic [32:0] out_log[$];
    logic        stall_q = 1'b0;
    logic [32:0] held;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] want);
        n_checks++;
        if (act !== want) begin
            n_errs++;
            $display("FAIL %s: got %0h expected %0h", nm, act, want);
        end
    endtask

    function automatic int rnd16(input int p);
        return (p + 32768) >>> 16;
    endfunction

    function automatic int clip8(input int v);
        return (v < 0) ? 0 : ((v > 255) ? 255 : v);
    endfunction

    // Reference: {sat, Y, Cr, Cb, A} or {0, input} in bypass.
    function automatic logic [32:0] ref_px(input logic [1:0] md, input logic [31:0] d);
        int r, g, b, y, cr, cb, kr, kb, kcr, kcb;
        logic s;
        logic [7:0] y8, cr8, cb8;
        if (md[1]) return {1'b0, d};
        r = int'(d[15:8]);
        g = int'(d[23:16]);
        b = int'(d[31:24]);
        if (md == 2'd0) begin
            kr = 19595; kb = 7471; kcr = 46745; kcb = 36984;
        end else begin
            kr = 13933; kb = 4732; kcr = 41615; kcb = 35318;
        end
        y  = g + rnd16(kr * (r - g)) + rnd16(kb * (b - g));
        cr = rnd16(kcr * (r - y)) + 128;
        cb = rnd16(kcb * (b - y)) + 128;
        s  = (clip8(y) != y) || (clip8(cr) != cr) || (clip8(cb) != cb);
        y8  = 8'(clip8(y));
        cr8 = 8'(clip8(cr));
        cb8 = 8'(clip8(cb));
        return {s, y8, cr8, cb8, d[7:0]};
    endfunction

    // One clock: drive inputs, score the handshakes due at the next edge, advance.
    task automatic step(input logic v, input logic [1:0] md, input logic [31:0] d,
                        input logic rdy, input logic r);
        logic [32:0] e;
        s_valid  = v;
        cfg_mode = md;
        s_data   = d;
        m_ready  = rdy;
        rst      = r;
        #1;
        if (stall_q) chk("stall_hold", {m_valid, m_sat, m_data}, {1'b1, held});
        if (r) chk("rst_s_ready", s_ready, 0);
        if (m_valid && m_ready) begin
            n_out++;
            out_log.push_back({m_sat, m_data});
            if (exp_q.size() == 0) begin
                chk("extra_output", {m_sat, m_data}, 64'hDEAD);
            end else begin
                e = exp_q.pop_front();
                chk("stream_px", {m_sat, m_data}, e);
            end
        end
        if (v && s_ready) begin
            n_acc++;
            exp_q.push_back(ref_px(md, d));
        end
        stall_q = m_valid && !m_ready;
        held    = {m_sat, m_data};
        @(posedge clk);
        #1;
        if (r) begin
            exp_q.delete();
            stall_q = 1'b0;
        end
    endtask

    initial begin
        int lat, sent, acc0, out0;
        vecs[0] = '{2'd0, 32'hFFFFFF5A, 32'hFF80805A, 1'b0};
        vecs[1] = '{2'd0, 32'h00000011, 32'h00808011, 1'b0};
        vecs[2] = '{2'd0, 32'h0000FF5A, 32'h4CFF555A, 1'b1};
        vecs[3] = '{2'd0, 32'hFF00005A, 32'h1D6BFF5A, 1'b1};
        vecs[4] = '{2'd1, 32'h0000FF00, 32'h36FF6300, 1'b1};
        vecs[5] = '{2'd1, 32'h00FF0033, 32'hB70C1D33, 1'b0};
        vecs[6] = '{2'd2, 32'h12345678, 32'h12345678, 1'b0};
        vecs[7] = '{2'd3, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0};

        rst = 1'b1; s_valid = 1'b0; cfg_mode = 2'd0; s_data = '0; m_ready = 1'b1;
        @(posedge clk); #1;
        chk("reset_s_ready", s_ready, 0);
        @(posedge clk); #1;
        chk("reset_m_valid", m_valid, 0);
        chk("reset_m_data", m_data, 0);
        chk("reset_m_sat", m_sat, 0);
        rst = 1'b0;

        // Hand-computed vectors, one at a time, with exact latency.
        for (int i = 0; i < 8; i++) begin
            cfg_mode = vecs[i].md;
            s_data   = vecs[i].din;
            s_valid  = 1'b1;
            m_ready  = 1'b1;
            #1;
            chk("tbl_s_ready", s_ready, 1);
            @(posedge clk); #1;
            s_valid = 1'b0;
            lat = 1;
            while (!m_valid && lat < 10) begin
                @(posedge clk); #1;
                lat++;
            end
            chk("tbl_latency", lat, 4);
            chk("tbl_data", m_data, vecs[i].dout);
            chk("tbl_sat", m_sat, vecs[i].sat);
        end
        @(posedge clk); #1;

        // Mode changes between consecutive pixels.
        out_log.delete();
        step(1'b1, 2'd0, 32'h0000FF5A, 1'b1, 1'b0);
        step(1'b1, 2'd1, 32'h00FF0033, 1'b1, 1'b0);
        step(1'b1, 2'd2, 32'hA1B2C3D4, 1'b1, 1'b0);
        for (int i = 0; i < 6; i++) step(1'b0, 2'd0, 32'h0, 1'b1, 1'b0);
        chk("mode_count", out_log.size(), 3);
        if (out_log.size() == 3) begin
            chk("mode_601", out_log[0], {1'b1, 32'h4CFF555A});
            chk("mode_709", out_log[1], {1'b0, 32'hB70C1D33});
            chk("mode_bypass", out_log[2], {1'b0, 32'hA1B2C3D4});
        end

        // Random stream with random backpressure and modes.
        sent = 0;
        out0 = n_out;
        for (int c = 0; c < 2000 && sent < 64; c++) begin
            acc0 = n_acc;
            step($urandom_range(0, 4) != 0, 2'($urandom_range(0, 3)), $urandom,
                 $urandom_range(0, 2) != 0, 1'b0);
            if (n_acc != acc0) sent++;
        end
        for (int c = 0; c < 50 && exp_q.size() != 0; c++) step(1'b0, 2'd0, 32'h0, 1'b1, 1'b0);
        chk("rand_sent", sent, 64);
        chk("rand_drain", exp_q.size(), 0);
        chk("rand_out_count", n_out - out0, 64);

        // Reset with three pixels in flight.
        for (int i = 1; i <= 3; i++) step(1'b1, 2'd2, 32'hDEAD0000 + 32'(i), 1'b1, 1'b0);
        step(1'b0, 2'd0, 32'h0, 1'b1, 1'b1);
        chk("rst_m_valid", m_valid, 0);
        out0 = n_out;
        step(1'b1, 2'd2, 32'h600D600D, 1'b1, 1'b0);
        for (int i = 0; i < 8; i++) step(1'b0, 2'd0, 32'h0, 1'b1, 1'b0);
        chk("rst_out_count", n_out - out0, 1);
        chk("rst_drain", exp_q.size(), 0);

        // Full stall: the pipe takes exactly four, then streams at full rate.
        acc0 = n_acc;
        for (int i = 0; i < 10; i++) step(1'b1, 2'd2, 32'hC0DE0000 + 32'(i), 1'b0, 1'b0);
        chk("stall_accepts", n_acc - acc0, 4);
        chk("stall_s_ready", s_ready, 0);
        acc0 = n_acc;
        out0 = n_out;
        for (int i = 0; i < 8; i++) step(1'b1, 2'd0, 32'h00FF0033 + 32'(i << 24), 1'b1, 1'b0);
        chk("release_accepts", n_acc - acc0, 8);
        chk("release_outputs", n_out - out0, 8);
        for (int i = 0; i < 6; i++) step(1'b0, 2'd0, 32'h0, 1'b1, 1'b0);
        chk("release_drain", exp_q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errs);
        $finish;
    end

endmodule
